object_bbox_tracker: RTL and testbench

OBJECT_BBOX_TRACKER -- requirements
Module: object_bbox_tracker

---
 rtl/object_bbox_tracker_pkg.sv | 20 ++
 rtl/global.vh | 6 +
 rtl/object_bbox_tracker_entry.sv | 45 ++++
 rtl/object_bbox_tracker.sv | 208 ++++++++++++++++++++
 tb/tb_object_bbox_tracker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/object_bbox_tracker_pkg.sv
// ============================================================================
// object_bbox_tracker_pkg : shared types and widths for the bbox tracker
// Revision: 1.0
// ============================================================================
`default_nettype none
`include "global.vh"

package object_bbox_tracker_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned WORD_W  = `WORD_SIZE;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/global.vh
`ifndef GLOBAL_VH
`define GLOBAL_VH
`define WORD_SIZE     8
`define OBJ_MAX       32
`define OBJ_CNT_WIDTH 20
`endif

// File: rtl/object_bbox_tracker_entry.sv
// ============================================================================
// bbox_entry_update : merges one pixel into a bounding-box/count entry
// Revision: 1.0
// ============================================================================
`default_nettype none

module bbox_entry_update
    import object_bbox_tracker_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 20
) (
    input  logic                 valid_i,
    input  logic [COORD_W-1:0]   x_i,
    input  logic [COORD_W-1:0]   y_i,
    input  logic [COORD_W-1:0]   min_x_i,
    input  logic [COORD_W-1:0]   max_x_i,
    input  logic [COORD_W-1:0]   min_y_i,
    input  logic [COORD_W-1:0]   max_y_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    output logic [COORD_W-1:0]   min_x_o,
    output logic [COORD_W-1:0]   max_x_o,
    output logic [COORD_W-1:0]   min_y_o,
    output logic [COORD_W-1:0]   max_y_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    always_comb begin
        min_x_o = x_i;
        max_x_o = x_i;
        min_y_o = y_i;
        max_y_o = y_i;
        count_o = CNT_WIDTH'(1);
        if (valid_i) begin
            min_x_o = (x_i < min_x_i) ? x_i : min_x_i;
            max_x_o = (x_i > max_x_i) ? x_i : max_x_i;
            min_y_o = (y_i < min_y_i) ? y_i : min_y_i;
            max_y_o = (y_i > max_y_i) ? y_i : max_y_i;
            // Saturate rather than wrap so huge blobs never look small
            count_o = (&count_i) ? count_i : count_i + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/object_bbox_tracker.sv
// ============================================================================
// object_bbox_tracker : per-label bounding boxes with double-buffered publish
// Revision: 1.0
// ============================================================================
`default_nettype none
`include "global.vh"

module object_bbox_tracker
    import object_bbox_tracker_pkg::*;
#(
    parameter int unsigned MAX_OBJS  = `OBJ_MAX,
    parameter int unsigned CNT_WIDTH = `OBJ_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  sof,
    input  logic                  eof,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    input  logic [`WORD_SIZE-1:0] label,
    input  logic [`WORD_SIZE-1:0] rd_id,
    output logic [COORD_W-1:0]    rd_min_x,
    output logic [COORD_W-1:0]    rd_max_x,
    output logic [COORD_W-1:0]    rd_min_y,
    output logic [COORD_W-1:0]    rd_max_y,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  rd_valid,
    output logic [`WORD_SIZE-1:0] obj_count,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int unsigned       IDX_W     = (MAX_OBJS > 1) ? $clog2(MAX_OBJS) : 1;
    localparam logic [WORD_W-1:0] C_MAX_LBL = WORD_W'(MAX_OBJS);

    state_t               state_q, state_d;
    logic                 pub_q, pub_d;
    logic                 ovf_q   [2];
    logic                 ovf_d   [2];
    logic                 valid_q [2][MAX_OBJS];
    logic                 valid_d [2][MAX_OBJS];
    logic [COORD_W-1:0]   min_x_q [2][MAX_OBJS];
    logic [COORD_W-1:0]   min_x_d [2][MAX_OBJS];
    logic [COORD_W-1:0]   max_x_q [2][MAX_OBJS];
    logic [COORD_W-1:0]   max_x_d [2][MAX_OBJS];
    logic [COORD_W-1:0]   min_y_q [2][MAX_OBJS];
    logic [COORD_W-1:0]   min_y_d [2][MAX_OBJS];
    logic [COORD_W-1:0]   max_y_q [2][MAX_OBJS];
    logic [COORD_W-1:0]   max_y_d [2][MAX_OBJS];
    logic [CNT_WIDTH-1:0] count_q [2][MAX_OBJS];
    logic [CNT_WIDTH-1:0] count_d [2][MAX_OBJS];

    logic                 rd_valid_q;
    logic [COORD_W-1:0]   rd_min_x_q, rd_max_x_q, rd_min_y_q, rd_max_y_q;
    logic [CNT_WIDTH-1:0] rd_count_q;
    logic [WORD_W-1:0]    obj_count_q;
    logic                 frame_done_q;
    logic                 overflow_q;

    logic                 w_start, w_pix, w_end, w_wb;
    logic                 w_lbl_ok, w_lbl_ovf;
    logic [IDX_W-1:0]     w_idx, w_rd_idx;
    logic                 w_cur_valid, w_rd_hit;
    logic [COORD_W-1:0]   w_new_min_x, w_new_max_x, w_new_min_y, w_new_max_y;
    logic [CNT_WIDTH-1:0] w_new_count;
    logic [WORD_W-1:0]    w_obj_cnt;

    assign w_start   = en & sof;
    assign w_pix     = en & (sof | (state_q == ST_ACCUM));
    assign w_end     = w_pix & eof;
    assign w_wb      = ~pub_q;
    assign w_lbl_ovf = (label >= C_MAX_LBL);
    assign w_lbl_ok  = (label != '0) && !w_lbl_ovf;
    assign w_idx     = label[IDX_W-1:0];
    assign w_rd_idx  = rd_id[IDX_W-1:0];

    // A start-of-frame pixel must see its entry as empty, as the bank is cleared this cycle
    assign w_cur_valid = ~w_start & valid_q[w_wb][w_idx];

    bbox_entry_update #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_entry_update (
        .valid_i (w_cur_valid),
        .x_i     (x),
        .y_i     (y),
        .min_x_i (min_x_q[w_wb][w_idx]),
        .max_x_i (max_x_q[w_wb][w_idx]),
        .min_y_i (min_y_q[w_wb][w_idx]),
        .max_y_i (max_y_q[w_wb][w_idx]),
        .count_i (count_q[w_wb][w_idx]),
        .min_x_o (w_new_min_x),
        .max_x_o (w_new_max_x),
        .min_y_o (w_new_min_y),
        .max_y_o (w_new_max_y),
        .count_o (w_new_count)
    );

    always_comb begin
        state_d = state_q;
        if (w_end) begin
            state_d = ST_IDLE;
        end else if (w_start) begin
            state_d = ST_ACCUM;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        count_d = count_q;
        pub_d   = pub_q;
        if (w_start) begin
            for (int i = 0; i < int'(MAX_OBJS); i++) begin
                valid_d[w_wb][i] = 1'b0;
            end
            ovf_d[w_wb] = 1'b0;
        end
        if (w_pix) begin
            if (w_lbl_ovf) begin
                ovf_d[w_wb] = 1'b1;
            end else if (w_lbl_ok) begin
                valid_d[w_wb][w_idx] = 1'b1;
                min_x_d[w_wb][w_idx] = w_new_min_x;
                max_x_d[w_wb][w_idx] = w_new_max_x;
                min_y_d[w_wb][w_idx] = w_new_min_y;
                max_y_d[w_wb][w_idx] = w_new_max_y;
                count_d[w_wb][w_idx] = w_new_count;
            end
        end
        if (w_end) begin
            pub_d = ~pub_q;
        end
    end

    // Reads and statistics look at the post-edge published bank, so a read at the publish edge sees new data
    always_comb begin
        w_rd_hit  = (rd_id < C_MAX_LBL) && valid_d[pub_d][w_rd_idx];
        w_obj_cnt = '0;
        for (int i = 0; i < int'(MAX_OBJS); i++) begin
            if (valid_d[pub_d][i]) begin
                w_obj_cnt = w_obj_cnt + WORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pub_q        <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                ovf_q[b] <= 1'b0;
                for (int i = 0; i < int'(MAX_OBJS); i++) begin
                    valid_q[b][i] <= 1'b0;
                end
            end
            rd_valid_q   <= 1'b0;
            rd_min_x_q   <= '0;
            rd_max_x_q   <= '0;
            rd_min_y_q   <= '0;
            rd_max_y_q   <= '0;
            rd_count_q   <= '0;
            obj_count_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pub_q        <= pub_d;
            ovf_q        <= ovf_d;
            valid_q      <= valid_d;
            rd_valid_q   <= w_rd_hit;
            rd_min_x_q   <= w_rd_hit ? min_x_d[pub_d][w_rd_idx] : '0;
            rd_max_x_q   <= w_rd_hit ? max_x_d[pub_d][w_rd_idx] : '0;
            rd_min_y_q   <= w_rd_hit ? min_y_d[pub_d][w_rd_idx] : '0;
            rd_max_y_q   <= w_rd_hit ? max_y_d[pub_d][w_rd_idx] : '0;
            rd_count_q   <= w_rd_hit ? count_d[pub_d][w_rd_idx] : '0;
            obj_count_q  <= w_obj_cnt;
            frame_done_q <= w_end;
            overflow_q   <= ovf_d[pub_d];
        end
    end

    // Entry payload is qualified by its valid bit, so it needs no reset
    always_ff @(posedge clk) begin
        min_x_q <= min_x_d;
        max_x_q <= max_x_d;
        min_y_q <= min_y_d;
        max_y_q <= max_y_d;
        count_q <= count_d;
    end

    assign rd_valid   = rd_valid_q;
    assign rd_min_x   = rd_min_x_q;
    assign rd_max_x   = rd_max_x_q;
    assign rd_min_y   = rd_min_y_q;
    assign rd_max_y   = rd_max_y_q;
    assign rd_count   = rd_count_q;
    assign obj_count  = obj_count_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_object_bbox_tracker.sv
// ============================================================================
// tb_object_bbox_tracker : directed self-checking bench for object_bbox_tracker
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_object_bbox_tracker;

    localparam int MAX_OBJS = 32;
    localparam int CNT_W    = 8;
    localparam int WW       = 8;

    logic          clk = 1'b0;
    logic          reset_n, en, sof, eof;
    logic [15:0]   x, y;
    logic [WW-1:0] label, rd_id;
    logic [15:0]   rd_min_x, rd_max_x, rd_min_y, rd_max_y;
    logic [CNT_W-1:0] rd_count;
    logic          rd_valid;
    logic [WW-1:0] obj_count;
    logic          frame_done, overflow;

    always #5 clk = ~clk;

    object_bbox_tracker #(
        .MAX_OBJS  (MAX_OBJS),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .sof        (sof),
        .eof        (eof),
        .x          (x),
        .y          (y),
        .label      (label),
        .rd_id      (rd_id),
        .rd_min_x   (rd_min_x),
        .rd_max_x   (rd_max_x),
        .rd_min_y   (rd_min_y),
        .rd_max_y   (rd_max_y),
        .rd_count   (rd_count),
        .rd_valid   (rd_valid),
        .obj_count  (obj_count),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic             valid;
        logic [15:0]      min_x;
        logic [15:0]      max_x;
        logic [15:0]      min_y;
        logic [15:0]      max_y;
        logic [CNT_W-1:0] cnt;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic s, input logic e, input int px, input int py, input int lb);
        en    = 1'b1;
        sof   = s;
        eof   = e;
        x     = px[15:0];
        y     = py[15:0];
        label = lb[WW-1:0];
        step();
        en  = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
    endtask

    task automatic push_exp(input logic v, input int mnx, input int mxx,
                            input int mny, input int mxy, input int cnt);
        rd_exp_t e;
        e.valid = v;
        e.min_x = mnx[15:0];
        e.max_x = mxx[15:0];
        e.min_y = mny[15:0];
        e.max_y = mxy[15:0];
        e.cnt   = cnt[CNT_W-1:0];
        exp_q.push_back(e);
    endtask

    task automatic check_rd(input string tag);
        rd_exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".valid"}, {31'd0, rd_valid}, {31'd0, e.valid});
            chk({tag, ".min_x"}, {16'd0, rd_min_x}, {16'd0, e.min_x});
            chk({tag, ".max_x"}, {16'd0, rd_max_x}, {16'd0, e.max_x});
            chk({tag, ".min_y"}, {16'd0, rd_min_y}, {16'd0, e.min_y});
            chk({tag, ".max_y"}, {16'd0, rd_max_y}, {16'd0, e.max_y});
            chk({tag, ".count"}, 32'(rd_count), 32'(e.cnt));
        end
    endtask

    task automatic rd(input int id, input logic v, input int mnx, input int mxx,
                      input int mny, input int mxy, input int cnt);
        push_exp(v, mnx, mxx, mny, mxy, cnt);
        rd_id = id[WW-1:0];
        step();
        check_rd($sformatf("rd%0d", id));
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; sof = 1'b0; eof = 1'b0;
        x = '0; y = '0; label = '0; rd_id = '0;
        step();
        step();
        chk("rst.frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst.overflow",   {31'd0, overflow},   32'd0);
        chk("rst.obj_count",  32'(obj_count),      32'd0);
        push_exp(1'b0, 0, 0, 0, 0, 0);
        check_rd("rst.rd");
        reset_n = 1'b1;
        step();

        // Frame A: three pixels of label 3
        pix(1'b1, 1'b0, 10, 5, 3);
        pix(1'b0, 1'b0, 12, 9, 3);
        pix(1'b0, 1'b1, 11, 2, 3);
        chk("A.frame_done", {31'd0, frame_done}, 32'd1);
        chk("A.obj_count",  32'(obj_count),      32'd1);
        chk("A.overflow",   {31'd0, overflow},   32'd0);
        step();
        chk("A.frame_done_pulse", {31'd0, frame_done}, 32'd0);
        rd(3, 1'b1, 10, 12, 2, 9, 3);
        rd(2, 1'b0, 0, 0, 0, 0, 0);

        // Background and out-of-range labels
        pix(1'b1, 1'b0, 1, 1, 0);
        pix(1'b0, 1'b0, 4, 4, 7);
        pix(1'b0, 1'b1, 2, 2, 40);
        chk("OVF.overflow",  {31'd0, overflow}, 32'd1);
        chk("OVF.obj_count", 32'(obj_count),    32'd1);
        rd(0,  1'b0, 0, 0, 0, 0, 0);
        rd(40, 1'b0, 0, 0, 0, 0, 0);
        rd(7,  1'b1, 4, 4, 4, 4, 1);
        rd(3,  1'b0, 0, 0, 0, 0, 0);

        // Frame B with a read aimed at the publish edge
        push_exp(1'b1, 50, 100, 200, 300, 2);
        rd_id = 8'd9;
        pix(1'b1, 1'b0, 100, 200, 9);
        pix(1'b0, 1'b1, 50, 300, 9);
        check_rd("B.edge_rd9");
        chk("B.overflow", {31'd0, overflow}, 32'd0);

        // Frame C in progress must not disturb the published frame B
        pix(1'b1, 1'b0, 1, 1, 9);
        pix(1'b0, 1'b0, 2, 2, 12);
        rd(9,  1'b1, 50, 100, 200, 300, 2);
        rd(12, 1'b0, 0, 0, 0, 0, 0);
        // Restart mid-frame discards C's partial data
        pix(1'b1, 1'b0, 3, 3, 12);
        pix(1'b0, 1'b1, 5, 6, 12);
        chk("R.frame_done", {31'd0, frame_done}, 32'd1);
        rd(12, 1'b1, 3, 5, 3, 6, 2);
        rd(9,  1'b0, 0, 0, 0, 0, 0);

        // One-pixel frame
        pix(1'b1, 1'b1, 7, 7, 5);
        chk("S.frame_done", {31'd0, frame_done}, 32'd1);
        chk("S.obj_count",  32'(obj_count),      32'd1);
        rd(5, 1'b1, 7, 7, 7, 7, 1);

        // Reset mid-frame, then a stray eof
        pix(1'b1, 1'b0, 1, 1, 4);
        pix(1'b0, 1'b0, 2, 2, 4);
        reset_n = 1'b0;
        step();
        chk("M.frame_done_rst", {31'd0, frame_done}, 32'd0);
        reset_n = 1'b1;
        step();
        pix(1'b0, 1'b1, 3, 3, 4);
        chk("M.frame_done_eof", {31'd0, frame_done}, 32'd0);
        step();
        chk("M.frame_done_late", {31'd0, frame_done}, 32'd0);
        chk("M.obj_count", 32'(obj_count), 32'd0);
        for (int i = 0; i < MAX_OBJS + 2; i++) begin
            rd(i, 1'b0, 0, 0, 0, 0, 0);
        end

        // Count saturation: 258 pixels of label 1
        pix(1'b1, 1'b0, 20, 500, 1);
        for (int i = 1; i <= 256; i++) begin
            pix(1'b0, 1'b0, i, 1000 - i, 1);
        end
        pix(1'b0, 1'b1, 300, 5, 1);
        chk("SAT.frame_done", {31'd0, frame_done}, 32'd1);
        rd(1, 1'b1, 1, 300, 5, 999, (1 << CNT_W) - 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
